reservation_arbiter: RTL

Shares the single seat-booking engine among N train-side requesters.
- Arbitration is round-robin with a req/gnt handshake; each engine transaction is sequenced with a start pulse, done/fault completion and a watchdog timeout.
- Transient engine faults are retried a bounded number of times.
- predict_flag from the predictive monitor pauses new grants, drains the in-flight transaction and runs a heal handshake with the healing unit before service resumes.

---
 rtl/train_pkg.sv | 28 ++
 rtl/rr_pick.sv | 46 ++++
 rtl/reservation_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/train_pkg.sv
`default_nettype none
// ============================================================================
// Module      : train_pkg
// Description : Shared types and defaults for the seat-booking reservation
//               arbiter (state encoding, default sizing, index-width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package train_pkg;

    localparam int c_DEF_N         = 4;
    localparam int c_DEF_MAX_RETRY = 2;
    localparam int c_DEF_TIMEOUT   = 15;

    // Requester index width; never below one bit so a two-way arbiter still has an index.
    function automatic int idw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_BUSY  = 3'd2,
        ST_RETRY = 3'd3,
        ST_HEAL  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector: first set request bit at
//               or after rr_ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick import train_pkg::*; #(
    parameter int N   = c_DEF_N,
    parameter int IDW = idw_of(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] rr_ptr,
    output logic [N-1:0]   pick_oh,
    output logic [IDW-1:0] pick_idx,
    output logic           pick_valid
);

    localparam logic [IDW:0] c_N = (IDW+1)'(N);

    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_k;

    always_comb begin
        pick_oh    = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        w_sum      = '0;
        w_k        = '0;
        for (int i = 0; i < N; i++) begin
            // One spare bit holds rr_ptr+i (at most 2N-2) before the modulo fold.
            w_sum = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            w_k = w_sum[IDW-1:0];
            if (!pick_valid && req[w_k]) begin
                pick_valid   = 1'b1;
                pick_idx     = w_k;
                pick_oh[w_k] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reservation_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reservation_arbiter
// Description : Round-robin arbiter sharing one seat-booking engine, with
//               bounded retry, watchdog timeout and predictive heal handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module reservation_arbiter import train_pkg::*; #(
    parameter int N         = c_DEF_N,
    parameter int IDW       = idw_of(N),
    parameter int MAX_RETRY = c_DEF_MAX_RETRY,
    parameter int TIMEOUT   = c_DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           eng_start,
    output logic [IDW-1:0] eng_id,
    input  logic           eng_done,
    input  logic           eng_fault,
    input  logic           predict_flag,
    output logic           heal_req,
    input  logic           heal_done,
    output logic [N-1:0]   done_vec,
    output logic [N-1:0]   err_vec,
    output logic           busy
);

    localparam logic [2:0]     c_MAX_RETRY = 3'(MAX_RETRY);
    localparam logic [7:0]     c_TIMEOUT   = 8'(TIMEOUT);
    localparam logic [IDW-1:0] c_LAST      = IDW'(N-1);

    state_t         r_state, w_state;
    logic [N-1:0]   r_gnt, w_gnt;
    logic [N-1:0]   r_done, w_done;
    logic [N-1:0]   r_err, w_err;
    logic [IDW-1:0] r_eng_id, w_eng_id;
    logic [IDW-1:0] r_rr_ptr, w_rr_ptr;
    logic [2:0]     r_retry, w_retry;
    logic [7:0]     r_tmo, w_tmo;
    logic           r_heal_pend, w_heal_pend;
    logic           r_eng_start, r_heal_req, r_busy;

    logic [N-1:0]   w_pick_oh;
    logic [IDW-1:0] w_pick_idx;
    logic           w_pick_valid;
    logic           w_fault;
    logic [IDW-1:0] w_ptr_nxt;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req        (req),
        .rr_ptr     (r_rr_ptr),
        .pick_oh    (w_pick_oh),
        .pick_idx   (w_pick_idx),
        .pick_valid (w_pick_valid)
    );

    // A timeout counts as a fault and outranks a simultaneous done.
    assign w_fault   = eng_fault || (r_tmo == c_TIMEOUT);
    assign w_ptr_nxt = (r_eng_id == c_LAST) ? '0 : r_eng_id + 1'b1;

    always_comb begin
        w_state     = r_state;
        w_gnt       = r_gnt;
        w_eng_id    = r_eng_id;
        w_rr_ptr    = r_rr_ptr;
        w_retry     = r_retry;
        w_tmo       = r_tmo;
        w_heal_pend = r_heal_pend;
        w_done      = '0;
        w_err       = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_heal_pend || predict_flag) begin
                    w_state = ST_HEAL;
                end else if (w_pick_valid) begin
                    w_state  = ST_ISSUE;
                    w_gnt    = w_pick_oh;
                    w_eng_id = w_pick_idx;
                end
            end
            ST_ISSUE: begin
                w_tmo   = '0;
                w_state = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_fault && (r_retry < c_MAX_RETRY)) begin
                    w_retry = r_retry + 3'd1;
                    w_state = ST_RETRY;
                end else if (w_fault || eng_done) begin
                    if (w_fault) begin
                        w_err[r_eng_id] = 1'b1;
                    end else begin
                        w_done[r_eng_id] = 1'b1;
                    end
                    w_gnt    = '0;
                    w_rr_ptr = w_ptr_nxt;
                    w_retry  = '0;
                    w_state  = ST_IDLE;
                end else begin
                    w_tmo = r_tmo + 8'd1;
                end
            end
            ST_RETRY: begin
                w_state = ST_ISSUE;
            end
            ST_HEAL: begin
                if (heal_done) begin
                    w_heal_pend = 1'b0;
                    w_state     = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
        // A prediction during a transaction never aborts it; heal follows the next IDLE.
        if (predict_flag && (r_state == ST_ISSUE || r_state == ST_BUSY || r_state == ST_RETRY)) begin
            w_heal_pend = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_eng_id    <= '0;
            r_rr_ptr    <= '0;
            r_retry     <= '0;
            r_tmo       <= '0;
            r_heal_pend <= 1'b0;
            r_eng_start <= 1'b0;
            r_heal_req  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_gnt       <= w_gnt;
            r_done      <= w_done;
            r_err       <= w_err;
            r_eng_id    <= w_eng_id;
            r_rr_ptr    <= w_rr_ptr;
            r_retry     <= w_retry;
            r_tmo       <= w_tmo;
            r_heal_pend <= w_heal_pend;
            r_eng_start <= (w_state == ST_ISSUE);
            r_heal_req  <= (w_state == ST_HEAL);
            r_busy      <= (w_state != ST_IDLE);
        end
    end

    assign gnt       = r_gnt;
    assign eng_start = r_eng_start;
    assign eng_id    = r_eng_id;
    assign heal_req  = r_heal_req;
    assign done_vec  = r_done;
    assign err_vec   = r_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire
